// File: rtl/rob_completion_arbiter_if.sv
// ---------------------------------------------------------------------------
// rob_completion_arbiter_if
//
// Purpose: bundles the per-unit completion inputs and the single registered
// completion record going to the reorder buffer.
//
// Parameters:
//   NUM_PORTS  number of execute units sharing the completion port (2..8)
//   IDXW       ROB index width
//
// Signals:
//   in_valid[NUM_PORTS]          unit i offers a completion record
//   in_ready[NUM_PORTS]          unit i's FIFO has room
//   in_rob_idx[NUM_PORTS*IDXW]   unit i's ROB index at [i*IDXW +: IDXW]
//   in_br_mispred/in_exception/in_ex_val[NUM_PORTS]  unit i's flags
//   ex_valid                     one-cycle pulse per completed record
//   rob_entry_idx/br_mispred/exception/ex_val        completed record
//   grant_port                   source unit of the current record
//
// Handshake: a unit transfers a record on a rising clock edge where both
// in_valid[i] and in_ready[i] are high. While in_valid[i] is high and
// in_ready[i] is low the unit must keep the record and its flags stable.
// The ROB side has no ready: every ex_valid pulse is consumed.
//
// Modports: master = execute units / bench, slave = the arbiter.
// ---------------------------------------------------------------------------
interface rob_completion_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int IDXW      = 6
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]      in_valid;
    logic [NUM_PORTS-1:0]      in_ready;
    logic [NUM_PORTS*IDXW-1:0] in_rob_idx;
    logic [NUM_PORTS-1:0]      in_br_mispred;
    logic [NUM_PORTS-1:0]      in_exception;
    logic [NUM_PORTS-1:0]      in_ex_val;

    logic                      ex_valid;
    logic [IDXW-1:0]           rob_entry_idx;
    logic                      br_mispred;
    logic                      exception;
    logic                      ex_val;
    logic [PW-1:0]             grant_port;

    modport master (
        output in_valid, in_rob_idx, in_br_mispred, in_exception, in_ex_val,
        input  in_ready,
        input  ex_valid, rob_entry_idx, br_mispred, exception, ex_val, grant_port
    );

    modport slave (
        input  in_valid, in_rob_idx, in_br_mispred, in_exception, in_ex_val,
        output in_ready,
        output ex_valid, rob_entry_idx, br_mispred, exception, ex_val, grant_port
    );
endinterface

// File: rtl/rob_completion_arbiter.sv
// ---------------------------------------------------------------------------
// rob_completion_arbiter
//
// Purpose: shares the single execute->ROB completion port among NUM_PORTS
// execute units. Every unit owns a private 2-entry FIFO of completion
// records; a round-robin arbiter picks one non-empty FIFO head per cycle and
// loads it into the registered completion record. The ROB always accepts.
// A ROB flush empties all FIFOs and suppresses the grant of that cycle.
//
// Parameters:
//   NUM_PORTS    execute units sharing the port (2..8)
//   ROB_ENTRIES  ROB depth, power of two (matches the core's ROB depth)
//
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   flush      ROB pipeline flush
//   cpl        rob_completion_arbiter_if.slave (unit inputs + ROB record)
//   rr_ptr_o   debug view of the round-robin pointer
//
// Optional feature (macro CPL_ARB_FLUSH_PRIO_EN):
//   When defined, FIFO heads carrying br_mispred or exception form a
//   priority class. If that class is non-empty the round-robin search runs
//   over it only, otherwise over all heads. The pointer advances the same
//   way in both cases (winner + 1). When undefined the flags play no part
//   in arbitration.
// ---------------------------------------------------------------------------
module rob_completion_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ROB_ENTRIES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    rob_completion_arbiter_if.slave       cpl,
    output logic [$clog2(NUM_PORTS)-1:0]  rr_ptr_o
);

    localparam int IDXW = $clog2(ROB_ENTRIES);
    localparam int PW   = $clog2(NUM_PORTS);
    // Record layout: {rob_idx, br_mispred, exception, ex_val}
    localparam int RW   = IDXW + 3;

    localparam int BIT_BR  = 2;
    localparam int BIT_EXC = 1;
    localparam int BIT_EXV = 0;

    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    // -----------------------------------------------------------------------
    // Per-unit FIFO storage. slot0 is always the head; slot1 is the second
    // entry. A pop shifts slot1 into slot0, so the head never needs a
    // read pointer.
    // -----------------------------------------------------------------------
    logic [RW-1:0]        slot0_q [NUM_PORTS];
    logic [RW-1:0]        slot1_q [NUM_PORTS];
    logic [1:0]           cnt_q   [NUM_PORTS];
    logic [1:0]           cnt_d   [NUM_PORTS];

    logic [RW-1:0]        in_rec  [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_ready;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;

    // Arbitration
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] arb_mask;
    logic                 grant_vld;
    logic [PW-1:0]        winner;
    logic [RW-1:0]        win_rec;
    logic [PW-1:0]        rr_ptr_q;
    logic [PW-1:0]        rr_ptr_d;

    // Registered completion record
    logic                 ex_valid_q;
    logic [IDXW-1:0]      rob_idx_q;
    logic                 br_q;
    logic                 exc_q;
    logic                 exv_q;
    logic [PW-1:0]        grant_q;

    // -----------------------------------------------------------------------
    // Input side: pack records, ready from occupancy, enqueue qualification.
    // A flush drops same-cycle enqueues even though in_ready is high; the
    // flushed unit's record belongs to a squashed instruction anyway.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_rec[i]   = {cpl.in_rob_idx[i*IDXW +: IDXW],
                           cpl.in_br_mispred[i],
                           cpl.in_exception[i],
                           cpl.in_ex_val[i]};
            in_ready[i] = (cnt_q[i] != 2'd2);
            push[i]     = cpl.in_valid[i] & in_ready[i] & ~flush;
        end
    end

    assign cpl.in_ready = in_ready;

    // -----------------------------------------------------------------------
    // Candidate selection. The priority class only exists when the optional
    // feature is compiled in.
    // -----------------------------------------------------------------------
`ifdef CPL_ARB_FLUSH_PRIO_EN
    logic [NUM_PORTS-1:0] hp;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = (cnt_q[i] != 2'd0);
            hp[i]   = cand[i] & (slot0_q[i][BIT_BR] | slot0_q[i][BIT_EXC]);
        end
        arb_mask = (|hp) ? hp : cand;
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = (cnt_q[i] != 2'd0);
        end
        arb_mask = cand;
    end
`endif

    // -----------------------------------------------------------------------
    // Round-robin search: first masked head at or after rr_ptr, wrapping
    // from NUM_PORTS-1 to 0. The wrap is done on an int so that non-power-
    // of-two port counts wrap at NUM_PORTS rather than at 2**PW.
    // -----------------------------------------------------------------------
    always_comb begin
        int            j;
        logic [PW-1:0] pos;
        logic          found;

        j      = 0;
        pos    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            pos = PW'(j);
            if (!found && arb_mask[pos]) begin
                found  = 1'b1;
                winner = pos;
            end
        end
        // Nothing is granted on a flush edge.
        grant_vld = found & ~flush;
    end

    assign win_rec = slot0_q[winner];

    always_comb begin
        if (grant_vld) begin
            rr_ptr_d = (winner == LAST_PORT) ? '0 : winner + PW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO occupancy next state
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i] = grant_vld & (winner == PW'(i));
            if (flush) begin
                cnt_d[i] = 2'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i]   <= 2'd0;
                slot0_q[i] <= '0;
                slot1_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (pop[i]) begin
                    slot0_q[i] <= slot1_q[i];
                end
                // The write slot is the occupancy left after this edge's pop.
                // The head write comes after the shift so it takes effect
                // when the FIFO drains to one entry on the same edge.
                if (push[i]) begin
                    if ((cnt_q[i] == 2'd0) || ((cnt_q[i] == 2'd1) && pop[i])) begin
                        slot0_q[i] <= in_rec[i];
                    end else begin
                        slot1_q[i] <= in_rec[i];
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered completion record. Payload registers hold their last value
    // when nothing is granted; only ex_valid drops.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            rob_idx_q  <= '0;
            br_q       <= 1'b0;
            exc_q      <= 1'b0;
            exv_q      <= 1'b0;
            grant_q    <= '0;
        end else if (grant_vld) begin
            ex_valid_q <= 1'b1;
            rob_idx_q  <= win_rec[RW-1:3];
            br_q       <= win_rec[BIT_BR];
            exc_q      <= win_rec[BIT_EXC];
            exv_q      <= win_rec[BIT_EXV];
            grant_q    <= winner;
        end else begin
            ex_valid_q <= 1'b0;
        end
    end

    assign cpl.ex_valid      = ex_valid_q;
    assign cpl.rob_entry_idx = rob_idx_q;
    assign cpl.br_mispred    = br_q;
    assign cpl.exception     = exc_q;
    assign cpl.ex_val        = exv_q;
    assign cpl.grant_port    = grant_q;
    assign rr_ptr_o          = rr_ptr_q;

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rob_completion_arbiter
//
// Bench for rob_completion_arbiter. A reference model keeps one queue of
// records per unit and an integer round-robin pointer; each clock edge it
// picks the winner from the queue heads, pops it, and accepts new records
// by the handshake rules. Directed scenarios add fixed expected values on
// top of the model comparison.
// ---------------------------------------------------------------------------
module tb_rob_completion_arbiter;

    localparam int NP   = 4;
    localparam int ROBN = 64;
    localparam int IDXW = 6;
    localparam int PW   = 2;
    localparam int RW   = IDXW + 3;
    localparam int VW   = 1 + RW + PW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [PW-1:0] dbg_rr;

    always #5 clk = ~clk;

    rob_completion_arbiter_if #(.NUM_PORTS(NP), .IDXW(IDXW)) bus ();

    rob_completion_arbiter #(
        .NUM_PORTS   (NP),
        .ROB_ENTRIES (ROBN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .cpl      (bus),
        .rr_ptr_o (dbg_rr)
    );

    // ---------------- model and stimulus state ----------------
    logic [RW-1:0]    fq  [NP][$];   // model FIFOs
    logic [RW-1:0]    src [NP][$];   // records each unit still wants to send
    logic [NP-1:0]    held;          // offered but not yet accepted
    logic [PW+RW-1:0] exp_q [$];     // scoreboard: {port, record}
    int               m_rr;
    logic             m_valid;
    logic [RW-1:0]    m_rec;
    logic [PW-1:0]    m_port;
    bit               rand_gaps;

    int n_checks;
    int n_fail;

    function automatic logic [RW-1:0] mk(input int idx, input bit br, input bit exc, input bit exv);
        return {IDXW'(idx), br, exc, exv};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.ex_valid, bus.rob_entry_idx, bus.br_mispred, bus.exception,
                bus.ex_val, bus.grant_port};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_valid, m_rec, m_port};
    endfunction

    function automatic logic [NP-1:0] exp_ready();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = (fq[i].size() < 2);
        return r;
    endfunction

    // Winner by the arbitration rules: first eligible head at or after m_rr.
    function automatic int pick();
        bit cand [NP];
        for (int i = 0; i < NP; i++) cand[i] = (fq[i].size() > 0);
`ifdef CPL_ARB_FLUSH_PRIO_EN
        begin
            bit any_hi;
            any_hi = 1'b0;
            for (int i = 0; i < NP; i++)
                if (cand[i] && (fq[i][0][2] || fq[i][0][1])) any_hi = 1'b1;
            if (any_hi)
                for (int i = 0; i < NP; i++)
                    cand[i] = cand[i] && (fq[i][0][2] || fq[i][0][1]);
        end
`endif
        for (int k = 0; k < NP; k++) begin
            if (cand[(m_rr + k) % NP]) return (m_rr + k) % NP;
        end
        return -1;
    endfunction

    // Model update for one rising edge, using pre-edge state and inputs.
    task automatic model_edge();
        bit rdy [NP];
        bit hs  [NP];
        int w;
        if (rst) begin
            for (int i = 0; i < NP; i++) fq[i].delete();
            exp_q.delete();
            m_rr = 0; m_valid = 1'b0; m_rec = '0; m_port = '0;
            held = '0;
            return;
        end
        for (int i = 0; i < NP; i++) begin
            rdy[i] = (fq[i].size() < 2);
            hs[i]  = bus.in_valid[i] && rdy[i];
        end
        if (flush) begin
            for (int i = 0; i < NP; i++) fq[i].delete();
            m_valid = 1'b0;
        end else begin
            w = pick();
            if (w >= 0) begin
                m_rec   = fq[w].pop_front();
                m_port  = PW'(w);
                m_valid = 1'b1;
                m_rr    = (w + 1) % NP;
                exp_q.push_back({m_port, m_rec});
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            // The unit sees the handshake complete; a flush silently drops it.
            if (hs[i]) begin
                if (!flush) fq[i].push_back(src[i][0]);
                void'(src[i].pop_front());
            end
            held[i] = bus.in_valid[i] && !hs[i];
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        logic [RW-1:0] r;
        for (int i = 0; i < NP; i++) begin
            if (src[i].size() > 0 && (held[i] || !rand_gaps || $urandom_range(0, 3) != 0)) begin
                bus.in_valid[i] = 1'b1;
                r = src[i][0];
            end else begin
                bus.in_valid[i] = 1'b0;
                r = RW'($urandom);
            end
            bus.in_rob_idx[i*IDXW +: IDXW] = r[RW-1:3];
            bus.in_br_mispred[i] = r[2];
            bus.in_exception[i]  = r[1];
            bus.in_ex_val[i]     = r[0];
        end
    endtask

    task automatic step();
        drive_inputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) src[i].delete();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (act_vec() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h exp 0", act_vec());
        end
        n_checks++;
        if (bus.in_ready !== 4'hF) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 1111", bus.in_ready);
        end
        n_checks++;
        if (dbg_rr !== '0) begin
            n_fail++; $display("FAIL reset_rr: got %0d exp 0", dbg_rr);
        end
    endtask

    task automatic test_single();
        do_reset();
        src[0].push_back(mk(5, 0, 0, 0));
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL single_n1: got %h exp %h", act_vec(), exp_vec());
        end
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.rob_entry_idx !== 6'd5 || bus.grant_port !== 2'd0) begin
            n_fail++; $display("FAIL single_n2: got v=%b idx=%0d port=%0d exp v=1 idx=5 port=0",
                               bus.ex_valid, bus.rob_entry_idx, bus.grant_port);
        end
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.rob_entry_idx !== 6'd5 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL single_hold: got %h exp %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_all_ports();
        do_reset();
        for (int i = 0; i < NP; i++) src[i].push_back(mk(i + 1, 0, 0, 1));
        step();
        for (int k = 0; k < NP; k++) begin
            step();
            n_checks++;
            if (bus.ex_valid !== 1'b1 || bus.rob_entry_idx !== IDXW'(k + 1) ||
                bus.grant_port !== PW'(k) || act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL all_ports[%0d]: got %h exp idx=%0d port=%0d model %h",
                                   k, act_vec(), k + 1, k, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int got [$];
        do_reset();
        for (int k = 0; k < 6; k++) begin
            src[0].push_back(mk(20 + k, 0, 0, 0));
            src[1].push_back(mk(30 + k, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) src[2].push_back(mk(10 + k, 0, 0, 0));
        step();
        step();
        n_checks++;
        if (bus.in_ready[2] !== 1'b0 || bus.in_ready !== exp_ready()) begin
            n_fail++; $display("FAIL b2b_full: got ready=%b exp unit2 low, model %b",
                               bus.in_ready, exp_ready());
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.ex_valid === 1'b1 && bus.grant_port === 2'd2) got.push_back(int'(bus.rob_entry_idx));
            step();
            n_checks++;
            if (act_vec() !== exp_vec() || bus.in_ready !== exp_ready()) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %h/%b exp %h/%b",
                                   c, act_vec(), bus.in_ready, exp_vec(), exp_ready());
            end
        end
        n_checks++;
        if (got.size() != 3 || got[0] != 10 || got[1] != 11 || got[2] != 12) begin
            n_fail++; $display("FAIL b2b_order: got %0d records %p exp 10 11 12", got.size(), got);
        end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        src[0].push_back(mk(40, 0, 0, 0));
        src[0].push_back(mk(43, 0, 0, 0));
        src[1].push_back(mk(41, 0, 0, 0));
        step();
        step();
        src[2].push_back(mk(42, 0, 0, 0));
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.in_ready !== 4'hF) begin
            n_fail++; $display("FAIL flush_edge: got v=%b ready=%b exp v=0 ready=1111",
                               bus.ex_valid, bus.in_ready);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.ex_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL flush_after: got %0d pulses exp 0", seen);
        end
    endtask

    task automatic test_prio();
        int first_idx;
        int second_idx;
`ifdef CPL_ARB_FLUSH_PRIO_EN
        first_idx = 9; second_idx = 7;
`else
        first_idx = 7; second_idx = 9;
`endif
        do_reset();
        src[0].push_back(mk(7, 0, 0, 0));
        src[3].push_back(mk(9, 0, 1, 0));
        step();
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.rob_entry_idx !== IDXW'(first_idx) || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL prio_first: got idx=%0d v=%b exp idx=%0d",
                               bus.rob_entry_idx, bus.ex_valid, first_idx);
        end
        step();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.rob_entry_idx !== IDXW'(second_idx) || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL prio_second: got idx=%0d v=%b exp idx=%0d",
                               bus.rob_entry_idx, bus.ex_valid, second_idx);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            src[i].push_back(mk(50 + i, 1, 0, 1));
            src[i].push_back(mk(60 + i, 0, 1, 1));
        end
        step();
        step();
        for (int i = 0; i < NP; i++) src[i].delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (act_vec() !== '0 || dbg_rr !== '0) begin
            n_fail++; $display("FAIL rst_mid_state: got out=%h rr=%0d exp 0/0", act_vec(), dbg_rr);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.ex_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || bus.in_ready !== 4'hF) begin
            n_fail++; $display("FAIL rst_mid_after: got %0d pulses ready=%b exp 0 / 1111", seen, bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic [PW+RW-1:0] e;
        int bad_vec;
        int bad_sb;
        int bad_rdy;
        int pulses;
        do_reset();
        exp_q.delete();
        rand_gaps = 1'b1;
        bad_vec = 0; bad_sb = 0; bad_rdy = 0; pulses = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (src[i].size() < 3 && $urandom_range(0, 2) == 0)
                    src[i].push_back(mk($urandom_range(0, ROBN - 1), $urandom_range(0, 5) == 0,
                                        $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1));
            end
            flush = ($urandom_range(0, 39) == 0);
            step();
            flush = 1'b0;
            if (act_vec() !== exp_vec() || dbg_rr !== PW'(m_rr)) begin
                bad_vec++;
                if (bad_vec < 5) $display("FAIL rand_out@%0d: got %h rr=%0d exp %h rr=%0d",
                                          c, act_vec(), dbg_rr, exp_vec(), m_rr);
            end
            if (bus.in_ready !== exp_ready()) begin
                bad_rdy++;
                if (bad_rdy < 5) $display("FAIL rand_ready@%0d: got %b exp %b", c, bus.in_ready, exp_ready());
            end
            if (bus.ex_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    bad_sb++;
                    if (bad_sb < 5) $display("FAIL rand_sb@%0d: got port=%0d idx=%0d exp none",
                                             c, bus.grant_port, bus.rob_entry_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.grant_port, bus.rob_entry_idx, bus.br_mispred, bus.exception, bus.ex_val} !== e) begin
                        bad_sb++;
                        if (bad_sb < 5) $display("FAIL rand_sb@%0d: got port=%0d idx=%0d exp %h",
                                                 c, bus.grant_port, bus.rob_entry_idx, e);
                    end
                end
            end
        end
        rand_gaps = 1'b0;
        n_checks++;
        if (bad_vec != 0) begin
            n_fail++; $display("FAIL rand_out_total: got %0d bad cycles exp 0", bad_vec);
        end
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++; $display("FAIL rand_ready_total: got %0d bad cycles exp 0", bad_rdy);
        end
        n_checks++;
        if (bad_sb != 0 || exp_q.size() != 0 || pulses < 300) begin
            n_fail++; $display("FAIL rand_scoreboard: got %0d bad, %0d left, %0d pulses exp 0/0/>=300",
                               bad_sb, exp_q.size(), pulses);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rand_gaps = 1'b0;
        held      = '0;
        rst       = 1'b1;
        flush     = 1'b0;
        m_rr      = 0;
        m_valid   = 1'b0;
        m_rec     = '0;
        m_port    = '0;
        bus.in_valid      = '0;
        bus.in_rob_idx    = '0;
        bus.in_br_mispred = '0;
        bus.in_exception  = '0;
        bus.in_ex_val     = '0;

        test_reset();
        test_single();
        test_all_ports();
        test_back_to_back();
        test_flush();
        test_prio();
        test_rst_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
